// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter unit with conditional branch, PC-relative jump/call and a
// small return-address stack (RAS).
//
// Parameters
//   WIDTH      PC / offset / stack entry width in bits
//   RAS_DEPTH  number of return-address-stack entries (>= 2)
//   INC        sequential PC increment in bytes
//   OFF_SHIFT  left shift applied to signext to form a byte offset
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   stall      freezes PC, stack, count and error flag
//   branch     conditional branch request
//   branch_ne  1 = bne, 0 = beq
//   alu_zero   ALU zero flag
//   jump       unconditional PC-relative jump
//   call       PC-relative call, pushes the return address
//   ret        return, pops the target from the stack
//   signext    sign-extended offset
//   pc         registered current PC
//   pc_next    value pc loads at the next edge (combinational)
//   ras_empty  stack holds no entries
//   ras_full   stack holds RAS_DEPTH entries
//   ras_err    sticky overflow / underflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4,
  parameter int INC       = 2,
  parameter int OFF_SHIFT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             alu_zero,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] signext,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // Entry 0 is always the top of stack; pushes shift towards the bottom so
  // the oldest entry simply falls off the end when the stack is full.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] tgt;
  logic             taken;
  logic             empty;
  logic             full;

  always_comb begin
    seq   = pc_q + WIDTH'(INC);
    tgt   = pc_q + (signext << OFF_SHIFT);
    taken = branch & (alu_zero ^ branch_ne);
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(RAS_DEPTH));
  end

  // Next-PC selection. ret outranks call, so a simultaneous call+ret returns
  // to the old top (or falls through to seq when the stack is empty).
  always_comb begin
    pc_d = seq;
    if (reset) begin
      pc_d = '0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      pc_d = empty ? seq : ras_q[0];
    end else if (call || jump || taken) begin
      pc_d = tgt;
    end
  end

  // Stack, count and sticky error update.
  always_comb begin
    ras_d   = ras_q;
    count_d = count_q;
    err_d   = err_q;
    if (!stall) begin
      unique case ({call, ret})
        2'b10: begin
          for (int i = RAS_DEPTH - 1; i > 0; i--) begin
            ras_d[i] = ras_q[i-1];
          end
          ras_d[0] = seq;
          if (full) begin
            err_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) begin
              ras_d[i] = ras_q[i+1];
            end
            count_d = count_q - CNT_W'(1);
          end
        end
        2'b11: begin
          // Non-empty: pop and push collapse into replacing the top.
          ras_d[0] = seq;
          if (empty) begin
            count_d = CNT_W'(1);
            err_d   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are meaningless after reset because count is cleared.
  always_ff @(posedge clock) begin
    ras_q <= ras_d;
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Directed self-checking bench for pc_unit with default parameters
// (WIDTH=16, RAS_DEPTH=4, INC=2, OFF_SHIFT=1). Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        branch_ne;
  logic        alu_zero;
  logic        jump;
  logic        call;
  logic        ret;
  logic [15:0] signext;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int total = 0;
  int bad   = 0;

  pc_unit #(
    .WIDTH(16),
    .RAS_DEPTH(4),
    .INC(2),
    .OFF_SHIFT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .branch(branch),
    .branch_ne(branch_ne),
    .alu_zero(alu_zero),
    .jump(jump),
    .call(call),
    .ret(ret),
    .signext(signext),
    .pc(pc),
    .pc_next(pc_next),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clock = ~clock;

  task automatic apply_stimulus(input logic rst, input logic stl,
                                input logic br, input logic bne,
                                input logic az, input logic jmp,
                                input logic cl, input logic rt,
                                input logic [15:0] off);
    reset     = rst;
    stall     = stl;
    branch    = br;
    branch_ne = bne;
    alu_zero  = az;
    jump      = jmp;
    call      = cl;
    ret       = rt;
    signext   = off;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f,
                             input logic r);
    check_output({tag, "_empty"}, 32'(ras_empty), 32'(e));
    check_output({tag, "_full"},  32'(ras_full),  32'(f));
    check_output({tag, "_err"},   32'(ras_err),   32'(r));
  endtask

  initial begin
    // Reset: pc_next forced to 0 even with stall high.
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
    check_output("rst_pc_next", 32'(pc_next), 32'h0);
    tick();
    check_output("rst_pc", 32'(pc), 32'h0);
    check_flags("rst", 1, 0, 0);

    // Three idle cycles.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    check_output("idle_pc_next", 32'(pc_next), 32'h2);
    tick();
    check_output("idle_pc1", 32'(pc), 32'h2);
    tick();
    check_output("idle_pc2", 32'(pc), 32'h4);
    tick();
    check_output("idle_pc3", 32'(pc), 32'h6);
    check_flags("idle", 1, 0, 0);

    // Jump 6 -> 0x10.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'h0005);
    tick();
    check_output("jump_pc", 32'(pc), 32'h10);

    // Branches at pc=0x10, offset -4 -> target 0x08.
    apply_stimulus(0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFC);
    check_output("beq_taken", 32'(pc_next), 32'h8);
    apply_stimulus(0, 0, 1, 1, 1, 0, 0, 0, 16'hFFFC);
    check_output("bne_not_taken", 32'(pc_next), 32'h12);
    apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0, 16'hFFFC);
    check_output("bne_taken", 32'(pc_next), 32'h8);
    apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 16'hFFFC);
    check_output("beq_not_taken", 32'(pc_next), 32'h12);

    // Jump 0x10 -> 0x100, then call +0x40 and return.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'h0078);
    tick();
    check_output("jump_pc_100", 32'(pc), 32'h100);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0020);
    check_output("call_pc_next", 32'(pc_next), 32'h140);
    tick();
    check_output("call_pc", 32'(pc), 32'h140);
    check_flags("call", 0, 0, 0);
    // A taken branch alongside ret is ignored.
    apply_stimulus(0, 0, 1, 0, 1, 1, 0, 1, 16'h0020);
    check_output("ret_pc_next", 32'(pc_next), 32'h102);
    tick();
    check_output("ret_pc", 32'(pc), 32'h102);
    check_flags("ret", 1, 0, 0);

    // Five calls at depth 4, offset +0x20 each.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0010);
    tick();
    check_output("c1_pc", 32'(pc), 32'h122);
    tick();
    tick();
    tick();
    check_output("c4_pc", 32'(pc), 32'h182);
    check_flags("c4", 0, 1, 0);
    tick();
    check_output("c5_pc", 32'(pc), 32'h1A2);
    check_flags("c5", 0, 1, 1);

    // Four returns in LIFO order; 0x104 was discarded.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);
    check_output("r1_pc_next", 32'(pc_next), 32'h184);
    tick();
    check_output("r1_pc", 32'(pc), 32'h184);
    check_output("r1_full", 32'(ras_full), 32'h0);
    tick();
    check_output("r2_pc", 32'(pc), 32'h164);
    tick();
    check_output("r3_pc", 32'(pc), 32'h144);
    tick();
    check_output("r4_pc", 32'(pc), 32'h124);
    check_flags("r4", 1, 0, 1);
    // Underflow falls through to seq.
    check_output("r5_pc_next", 32'(pc_next), 32'h126);
    tick();
    check_output("r5_pc", 32'(pc), 32'h126);
    check_flags("r5", 1, 0, 1);

    // Error is sticky across idle cycles; reset clears it.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tick();
    check_output("err_sticky", 32'(ras_err), 32'h1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tick();
    check_output("rst2_pc", 32'(pc), 32'h0);
    check_flags("rst2", 1, 0, 0);

    // Stall for three cycles with call asserted.
    apply_stimulus(0, 1, 0, 0, 0, 0, 1, 0, 16'h0010);
    check_output("stall_pc_next", 32'(pc_next), 32'h0);
    tick();
    tick();
    tick();
    check_output("stall_pc", 32'(pc), 32'h0);
    check_flags("stall", 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0010);
    check_output("unstall_pc_next", 32'(pc_next), 32'h20);
    tick();
    check_output("unstall_pc", 32'(pc), 32'h20);
    check_flags("unstall", 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check_output("unstall_ret_pc", 32'(pc), 32'h2);

    // call+ret with non-empty stack replaces the top.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0010);
    tick();
    check_output("cr_call_pc", 32'(pc), 32'h22);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h0010);
    check_output("cr_pc_next", 32'(pc_next), 32'h4);
    tick();
    check_output("cr_pc", 32'(pc), 32'h4);
    check_flags("cr", 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check_output("cr_ret_pc", 32'(pc), 32'h24);
    check_flags("cr_ret", 1, 0, 0);

    // call+ret with empty stack pushes seq and flags an error.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 16'h0010);
    check_output("cre_pc_next", 32'(pc_next), 32'h26);
    tick();
    check_output("cre_pc", 32'(pc), 32'h26);
    check_flags("cre", 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check_output("cre_ret_pc", 32'(pc), 32'h26);
    check_flags("cre_ret", 1, 0, 1);

    // Jump to 0xFFFE, then wrap to 0.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'hFFEC);
    tick();
    check_output("wrap_jump_pc", 32'(pc), 32'hFFFE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tick();
    check_output("wrap_pc", 32'(pc), 32'h0);

    // Reset during stall+ret with a non-empty stack.
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0010);
    tick();
    check_output("pre_rst_pc", 32'(pc), 32'h20);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 1, 16'h0000);
    check_output("rst3_pc_next", 32'(pc_next), 32'h0);
    tick();
    check_output("rst3_pc", 32'(pc), 32'h0);
    check_flags("rst3", 1, 0, 0);
    // Nothing survived: ret underflows to seq.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);
    tick();
    check_output("post_rst_ret_pc", 32'(pc), 32'h2);
    check_flags("post_rst_ret", 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the PC, offset and return-stack entry width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, SHALL set the number of return-address-stack entries (>=2).
REQ-003 Parameter INC, default 2, SHALL set the sequential PC increment in bytes.
REQ-004 Parameter OFF_SHIFT, default 1, SHALL set the left shift applied to signext to form a byte offset.
REQ-005 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-007 stall  in  1  SHALL freeze PC and stack when high.
REQ-008 branch  in  1  SHALL flag a conditional branch.
REQ-009 branch_ne  in  1  SHALL select bne (1) or beq (0) for a conditional branch.
REQ-010 alu_zero  in  1  SHALL be the ALU zero flag.
REQ-011 jump  in  1  SHALL flag an unconditional PC-relative jump.
REQ-012 call  in  1  SHALL flag a PC-relative call that pushes the return address.
REQ-013 ret  in  1  SHALL flag a return that pops the target.
REQ-014 signext  in  WIDTH  SHALL carry the sign-extended offset.
REQ-015 pc  out  WIDTH  SHALL be the registered current PC.
REQ-016 pc_next  out  WIDTH  SHALL be the combinational value pc loads at the next edge.
REQ-017 ras_empty  out  1  SHALL be high when the stack holds 0 entries.
REQ-018 ras_full  out  1  SHALL be high when the stack holds RAS_DEPTH entries.
REQ-019 ras_err  out  1  SHALL be a sticky flag for stack overflow/underflow.

Function
REQ-020 seq = pc + INC; tgt = pc + (signext << OFF_SHIFT); both SHALL be truncated to WIDTH bits, wrapping modulo 2^WIDTH.
REQ-021 taken SHALL equal branch & (alu_zero XOR branch_ne).
REQ-022 pc_next priority SHALL be: reset -> 0; stall -> pc; ret (stack non-empty) -> top entry; ret (empty) -> seq; call or jump -> tgt; taken -> tgt; otherwise seq.
REQ-023 At each rising edge with reset low and stall low, pc SHALL load pc_next; latency from inputs to pc is one cycle.
REQ-024 call alone SHALL push seq; when not full, count increments by 1.
REQ-025 call when full SHALL discard the oldest entry, push seq as top, hold count at RAS_DEPTH and set ras_err.
REQ-026 ret alone when non-empty SHALL pop the top and decrement count by 1.
REQ-027 ret when empty SHALL leave the stack unchanged, use seq, and set ras_err.
REQ-028 call and ret together, non-empty, SHALL replace the top with seq, keep count, and set pc_next = old top.
REQ-029 call and ret together, empty, SHALL push seq (count 1), set pc_next = seq and set ras_err.
REQ-030 branch, jump and taken SHALL be ignored whenever ret or call is high.
REQ-031 While stall is high, pc, stack contents, count and ras_err SHALL hold, regardless of other inputs.
REQ-032 ras_err SHALL remain set until reset.
REQ-033 ras_empty and ras_full SHALL decode the registered count only; no combinational path exists from call/ret to these flags.

Reset
REQ-034 While reset is high, pc_next SHALL be 0, overriding stall.
REQ-035 At an edge with reset high, the block SHALL set pc = 0 and count = 0, clear ras_err, set ras_empty = 1 and ras_full = 0; stack entry contents are don't-care.
REQ-036 Reset asserted mid-operation, including during stall or call/ret, SHALL take effect at that edge with no pending push or pop surviving.

Verification
REQ-037 Reset then 3 idle cycles -> pc = 0, 2, 4, 6; ras_empty = 1; ras_err = 0.
REQ-038 pc = 0x0010, branch = 1, branch_ne = 0, alu_zero = 1, signext = 0xFFFC -> pc_next = 0x0008; same with branch_ne = 1 -> pc_next = 0x0012.
REQ-039 pc = 0x0100, call with signext = 0x0020 -> pc = 0x0140 and top = 0x0102; then ret -> pc = 0x0102 and ras_empty = 1.
REQ-040 5 calls at RAS_DEPTH = 4 -> ras_full = 1, ras_err = 1; 4 rets return the last 4 return addresses in LIFO order; a 5th ret gives pc = seq with ras_empty = 1.
REQ-041 stall held 3 cycles with call asserted -> pc and count unchanged; on stall release the call completes in 1 cycle.
REQ-042 pc = 0xFFFE, idle -> pc = 0x0000 (wrap); reset asserted while stall = 1 and ret = 1 -> pc = 0, ras_empty = 1, ras_err = 0.
